cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller with one 32-bit word per line.
- Sits between the CPU load/store port and the single-port word RAM. It is the RAM's only master and drives its address/data/write inputs.
- Serves read hits from internal line storage. Forwards every miss and every write to RAM using the RAM's change-triggered response handshake.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cache_ctrl_mem_port.sv | 82 ++++++++
 rtl/cache_ctrl.sv | 153 +++++++++++++++
 tb/tb_cache_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache controller slice.
//   state_t  - controller / memory-port phase encoding
//   clog2    - ceiling log2 for deriving index widths from LINES
//   C_*      - default geometry and the index/tag widths derived from it
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int C_LINES  = 16;
  localparam int C_ADDR_W = 32;
  localparam int C_DATA_W = 32;
  localparam int C_IDX_W  = clog2(C_LINES);
  localparam int C_TAG_W  = C_ADDR_W - C_IDX_W;

endpackage

// File: rtl/cache_ctrl_mem_port.sv
// cache_ctrl_mem_port: sole master of the word RAM.
//   i_issue/i_write/i_addr/i_wdata - request from the controller (one-cycle issue)
//   o_dup      - the issued triple equals the last completed one; the RAM
//                will not re-trigger, so the controller completes at once
//   o_resp_hi  - response rising seen while waiting (WAIT_HI -> WAIT_LO)
//   o_done     - response falling seen; o_rdata carries the RAM read data
//   o_mem_*    - registered RAM address/data/write, held between accesses
//   i_mem_response/i_mem_out - RAM handshake flag and read data
module cache_ctrl_mem_port
  import cache_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_dup,
  output logic              o_resp_hi,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [31:0]       o_mem_address,
  output logic [31:0]       o_mem_data,
  output logic              o_mem_write,
  input  logic              i_mem_response,
  input  logic [31:0]       i_mem_out
);

  state_t      r_phase;
  logic        r_last_valid;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_data;
  logic        r_mem_write;

  logic [31:0] w_addr32;
  logic [31:0] w_data32;

  assign w_addr32 = 32'(i_addr);
  assign w_data32 = 32'(i_wdata);

  // The mem_* registers are the last issued triple, so no separate copy.
  assign o_dup = r_last_valid && (r_mem_write == i_write) &&
                 (r_mem_address == w_addr32) && (r_mem_data == w_data32);

  assign o_resp_hi = (r_phase == WAIT_HI) &&  i_mem_response;
  assign o_done    = (r_phase == WAIT_LO) && !i_mem_response;
  assign o_rdata   = DATA_W'(i_mem_out);

  assign o_mem_address = r_mem_address;
  assign o_mem_data    = r_mem_data;
  assign o_mem_write   = r_mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase       <= IDLE;
      r_last_valid  <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_write   <= 1'b0;
    end else begin
      case (r_phase)
        IDLE: if (i_issue) begin
          r_mem_address <= w_addr32;
          r_mem_data    <= w_data32;
          r_mem_write   <= i_write;
          // A duplicate never leaves IDLE: the RAM sees no change.
          if (!o_dup) r_phase <= WAIT_HI;
        end
        WAIT_HI: if (i_mem_response) r_phase <= WAIT_LO;
        WAIT_LO: if (!i_mem_response) begin
          r_phase      <= IDLE;
          r_last_valid <= 1'b1;
        end
        default: r_phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache, one word
// per line, between the CPU load/store port and a single-port word RAM.
//   clk, rst                       - clock, async active-high reset
//   cpu_req/write/addr/wdata       - CPU request, sampled only in IDLE
//   cpu_ready/rdata/hit            - one-cycle completion pulse with result
//   mem_address/data/write         - registered RAM request
//   mem_response/mem_out           - RAM change-triggered handshake + read data
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES  = C_LINES,
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_write,
  input  logic              mem_response,
  input  logic [31:0]       mem_out
);

  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t              r_state;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic                r_hit;
  logic [DATA_W-1:0]   r_rdata;

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_issue;
  logic                w_dup;
  logic                w_resp_hi;
  logic                w_done;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic                w_fill;
  logic                w_upd;

  assign w_idx = r_addr[IDX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:IDX_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Read hits are the only accesses that stay off the RAM.
  assign w_issue = (r_state == LOOKUP) && (r_write || !w_hit);

  // Reads allocate only after a real RAM access; a duplicate read just
  // returns the RAM's held output.
  assign w_fill = (r_state == WAIT_LO) && w_done && !r_write;
  assign w_upd  = r_write && w_hit &&
                  (((r_state == LOOKUP) && w_dup) ||
                   ((r_state == WAIT_LO) && w_done));

  cache_ctrl_mem_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_port (
    .clk            (clk),
    .rst            (rst),
    .i_issue        (w_issue),
    .i_write        (r_write),
    .i_addr         (r_addr),
    .i_wdata        (r_wdata),
    .o_dup          (w_dup),
    .o_resp_hi      (w_resp_hi),
    .o_done         (w_done),
    .o_rdata        (w_mem_rdata),
    .o_mem_address  (mem_address),
    .o_mem_data     (mem_data),
    .o_mem_write    (mem_write),
    .i_mem_response (mem_response),
    .i_mem_out      (mem_out)
  );

  // Line tag/data need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= w_mem_rdata;
    end else if (w_upd) begin
      r_data[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_hit   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_fill) r_valid[w_idx] <= 1'b1;
      case (r_state)
        IDLE: if (cpu_req) begin
          r_write <= cpu_write;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          if (!r_write && w_hit) begin
            r_ready <= 1'b1;
            r_hit   <= 1'b1;
            r_rdata <= r_data[w_idx];
            r_state <= IDLE;
          end else if (w_dup) begin
            r_ready <= 1'b1;
            r_hit   <= r_write && w_hit;
            if (!r_write) r_rdata <= w_mem_rdata;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT_HI;
          end
        end
        WAIT_HI: if (w_resp_hi) r_state <= WAIT_LO;
        WAIT_LO: if (w_done) begin
          r_ready <= 1'b1;
          r_hit   <= r_write && w_hit;
          if (!r_write) r_rdata <= w_mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_hit   = r_hit;
  assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_write;
  logic        mem_response;
  logic [31:0] mem_out;

  int total = 0;
  int bad   = 0;

  cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_write    (cpu_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .cpu_hit      (cpu_hit),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .mem_response (mem_response),
    .mem_out      (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: a change on its inputs raises response next edge; the edge
  // after that drops response and performs the access.
  logic [31:0] ram [0:255];
  logic [64:0] ram_prev = {1'b0, 32'h0, 32'h0};
  initial begin
    mem_response = 1'b0;
    mem_out      = 32'h0;
  end
  always @(posedge clk) begin
    if ({mem_write, mem_address, mem_data} !== ram_prev) begin
      ram_prev     <= {mem_write, mem_address, mem_data};
      mem_response <= 1'b1;
    end else if (mem_response) begin
      mem_response <= 1'b0;
      if (mem_write) ram[mem_address[7:0]] <= mem_data;
      else           mem_out <= ram[mem_address[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU transaction; lat counts edges after the accepting edge N.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic h,
                      output logic saw_resp);
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = 0; saw_resp = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (mem_response) saw_resp = 1'b1;
    end while (!cpu_ready && lat < 20);
    if (!cpu_ready) lat = 99;
    rd = cpu_rdata; h = cpu_hit;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        h;
  logic        sr;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h03] = 32'h0000_0033;
    ram[8'h13] = 32'h0000_1313;
    rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_hit",   32'(cpu_hit),   32'd0);
    chk("rst_rdata", cpu_rdata,      32'd0);
    chk("rst_maddr", mem_address,    32'd0);
    chk("rst_mwr",   32'(mem_write), 32'd0);
    @(negedge clk); rst = 1'b0;

    // cold read miss
    xact(1'b0, 32'h10, 32'h0, lat, rd, h, sr);
    chk("rd10_lat", 32'(lat), 32'd4);
    chk("rd10_hit", 32'(h), 32'd0);
    chk("rd10_data", rd, 32'hDEADBEEF);
    // read hit, RAM request untouched
    xact(1'b0, 32'h10, 32'h0, lat, rd, h, sr);
    chk("rh10_lat", 32'(lat), 32'd1);
    chk("rh10_hit", 32'(h), 32'd1);
    chk("rh10_data", rd, 32'hDEADBEEF);
    chk("rh10_maddr", mem_address, 32'h10);
    chk("rh10_mwr", 32'(mem_write), 32'd0);
    chk("rh10_resp", 32'(sr), 32'd0);

    // write hit
    xact(1'b1, 32'h10, 32'h12345678, lat, rd, h, sr);
    chk("wh10_lat", 32'(lat), 32'd4);
    chk("wh10_hit", 32'(h), 32'd1);
    chk("wh10_ram", ram[8'h10], 32'h12345678);
    xact(1'b0, 32'h10, 32'h0, lat, rd, h, sr);
    chk("rh10b_lat", 32'(lat), 32'd1);
    chk("rh10b_hit", 32'(h), 32'd1);
    chk("rh10b_data", rd, 32'h12345678);

    // write miss: no allocate
    xact(1'b1, 32'h25, 32'hA5A5A5A5, lat, rd, h, sr);
    chk("wm25_lat", 32'(lat), 32'd4);
    chk("wm25_hit", 32'(h), 32'd0);
    chk("wm25_ram", ram[8'h25], 32'hA5A5A5A5);
    xact(1'b0, 32'h25, 32'h0, lat, rd, h, sr);
    chk("rm25_lat", 32'(lat), 32'd4);
    chk("rm25_hit", 32'(h), 32'd0);
    chk("rm25_data", rd, 32'hA5A5A5A5);

    // conflicts on line 3
    xact(1'b0, 32'h03, 32'h0, lat, rd, h, sr);
    chk("c03a_hit", 32'(h), 32'd0);
    chk("c03a_data", rd, 32'h33);
    xact(1'b0, 32'h13, 32'h0, lat, rd, h, sr);
    chk("c13_hit", 32'(h), 32'd0);
    chk("c13_data", rd, 32'h1313);
    xact(1'b0, 32'h03, 32'h0, lat, rd, h, sr);
    chk("c03b_lat", 32'(lat), 32'd4);
    chk("c03b_hit", 32'(h), 32'd0);
    chk("c03b_data", rd, 32'h33);
    xact(1'b0, 32'h13, 32'h0, lat, rd, h, sr);
    chk("c13b_hit", 32'(h), 32'd0);
    chk("c13b_data", rd, 32'h1313);

    // duplicate write: RAM does not re-trigger
    xact(1'b1, 32'h40, 32'h5, lat, rd, h, sr);
    chk("w40a_lat", 32'(lat), 32'd4);
    chk("w40a_hit", 32'(h), 32'd0);
    xact(1'b1, 32'h40, 32'h5, lat, rd, h, sr);
    chk("w40b_lat", 32'(lat), 32'd1);
    chk("w40b_resp", 32'(sr), 32'd0);
    chk("w40b_ram", ram[8'h40], 32'h5);

    // reset while in WAIT_LO of a read miss
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h03; cpu_wdata = 32'h0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_resp", 32'(mem_response), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(cpu_ready), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_maddr", mem_address, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_ready", 32'(cpu_ready), 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(cpu_ready), 32'd0);
    xact(1'b0, 32'h03, 32'h0, lat, rd, h, sr);
    chk("pr03_lat", 32'(lat), 32'd4);
    chk("pr03_hit", 32'(h), 32'd0);
    chk("pr03_data", rd, 32'h33);
    xact(1'b0, 32'h10, 32'h0, lat, rd, h, sr);
    chk("pr10_lat", 32'(lat), 32'd4);
    chk("pr10_hit", 32'(h), 32'd0);
    chk("pr10_data", rd, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
